// File: rtl/dmem_responder_if.sv
// Bus bundle between the core's MEM stage (master) and dmem_responder (slave).
interface dmem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              misalign;
  logic [15:0]       rd_cnt;
  logic [15:0]       wr_cnt;

  modport master (
    output wr, rd, addr, funct3, wr_data,
    input  rd_data, misalign, rd_cnt, wr_cnt
  );

  modport slave (
    input  wr, rd, addr, funct3, wr_data,
    output rd_data, misalign, rd_cnt, wr_cnt
  );
endinterface

// File: rtl/dmem_responder.sv
// RV32I data memory: byte-lane storage, combinational loads, RV32I sized stores.
// Optional macro DMEM_ALIGN_CHECK_EN suppresses misaligned half/word accesses.

module dmem_lane #(
  parameter int DEPTH_W = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [DEPTH_W-1:0] widx,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata
);
  logic [7:0] mem [2**DEPTH_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**DEPTH_W; i++) mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[widx];
endmodule

module dmem_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic          clk,
  input  logic          reset,
  dmem_responder_if.slave bus
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int DEPTH_W   = ADDR_W - 2;

  typedef struct packed {
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        funct3;
    logic [DATA_W-1:0] wr_data;
  } req_t;

  req_t req;

  always_comb begin
    req.wr      = bus.wr;
    req.rd      = bus.rd;
    req.addr    = bus.addr;
    req.funct3  = bus.funct3;
    req.wr_data = bus.wr_data;
  end

  logic [DEPTH_W-1:0] widx;
  logic [1:0]         boff;
  logic               is_byte, is_half, is_word;
  logic               ld_valid, st_valid, mis_geom;
  logic               rd_sup, wr_sup;
  logic               do_rd, do_wr, rd_inc;

  assign widx = req.addr[ADDR_W-1:2];
  assign boff = req.addr[1:0];

  assign is_byte  = (req.funct3[1:0] == 2'b00);
  assign is_half  = (req.funct3[1:0] == 2'b01);
  assign is_word  = (req.funct3 == 3'b010);
  assign ld_valid = is_byte | is_half | is_word;
  assign st_valid = ~req.funct3[2] & ld_valid;
  assign mis_geom = (is_half & boff[0]) | (is_word & (boff != 2'b00));

`ifdef DMEM_ALIGN_CHECK_EN
  assign rd_sup = req.rd & ld_valid & mis_geom;
  assign wr_sup = req.wr & st_valid & mis_geom;
`else
  // Offending low bits are simply dropped by the lane decode below.
  assign rd_sup = 1'b0;
  assign wr_sup = 1'b0;
`endif

  assign do_rd  = req.rd & ld_valid & ~rd_sup;
  assign do_wr  = req.wr & st_valid & ~wr_sup;
  assign rd_inc = req.rd & ~rd_sup;

  logic [NUM_LANES-1:0][7:0] lane_rdata;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam int  LSEL = g % 4;
    localparam int  HSEL = g % 2;
    localparam bit  LOW4 = (g < 4);
    logic       we;
    logic [7:0] wd;

    always_comb begin
      we = 1'b0;
      wd = req.wr_data[8*g +: 8];
      if (do_wr) begin
        if (is_byte) begin
          we = LOW4 && (boff == 2'(LSEL));
          wd = req.wr_data[7:0];
        end else if (is_half) begin
          we = LOW4 && (boff[1] == LSEL[1]);
          wd = req.wr_data[8*HSEL +: 8];
        end else begin
          we = 1'b1;
        end
      end
    end

    dmem_lane #(.DEPTH_W(DEPTH_W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .widx  (widx),
      .wdata (wd),
      .rdata (lane_rdata[g])
    );
  end

  logic [DATA_W-1:0] word_r;
  logic [7:0]        byte_r;
  logic [15:0]       half_r;

  assign word_r = lane_rdata;
  assign byte_r = word_r[8*boff +: 8];
  assign half_r = boff[1] ? word_r[31:16] : word_r[15:0];

  always_comb begin
    bus.rd_data = '0;
    if (do_rd) begin
      case (req.funct3)
        3'b000:  bus.rd_data = {{(DATA_W-8){byte_r[7]}}, byte_r};
        3'b100:  bus.rd_data = {{(DATA_W-8){1'b0}}, byte_r};
        3'b001:  bus.rd_data = {{(DATA_W-16){half_r[15]}}, half_r};
        3'b101:  bus.rd_data = {{(DATA_W-16){1'b0}}, half_r};
        3'b010:  bus.rd_data = word_r;
        default: bus.rd_data = '0;
      endcase
    end
  end

  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_inc && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (do_wr  && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign bus.rd_cnt = rd_cnt_q;
  assign bus.wr_cnt = wr_cnt_q;

`ifdef DMEM_ALIGN_CHECK_EN
  logic misalign_q;

  // Sticky until reset: software polls it after the fact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  misalign_q <= 1'b0;
    else if (rd_sup || wr_sup)  misalign_q <= 1'b1;
  end

  assign bus.misalign = misalign_q;
`else
  assign bus.misalign = 1'b0;
`endif
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data bus width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 9, byte-address width; storage depth is 2^(ADDR_W-2) words (128 at default).
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port wr, input, 1, store request from the core's MEM stage.
REQ-006 The block SHALL have port rd, input, 1, load request from the core's MEM stage.
REQ-007 The block SHALL have port addr, input, ADDR_W, little-endian byte address.
REQ-008 The block SHALL have port funct3, input, 3, access size and sign per the RV32I load/store encoding.
REQ-009 The block SHALL have port wr_data, input, DATA_W, store data, right-aligned.
REQ-010 The block SHALL have port rd_data, output, DATA_W, load result, extended to DATA_W.
REQ-011 The block SHALL have port misalign, output, 1, sticky misaligned-access flag.
REQ-012 The block SHALL have port rd_cnt, output, 16, saturating load counter.
REQ-013 The block SHALL have port wr_cnt, output, 16, saturating store counter.

Function
REQ-014 Word index SHALL be addr[ADDR_W-1:2] and byte lane SHALL be addr[1:0], with byte 0 in bits 7:0.
REQ-015 Reads SHALL be combinational, with zero latency: rd_data SHALL be valid in the same cycle that rd=1.
REQ-016 For funct3 000 (LB) rd_data SHALL be the addressed byte sign-extended; for 100 (LBU), zero-extended.
REQ-017 For funct3 001 (LH) rd_data SHALL be the half selected by addr[1], sign-extended; for 101 (LHU), zero-extended.
REQ-018 For funct3 010 (LW) rd_data SHALL be the full word.
REQ-019 rd_data SHALL be 0 when rd=0 or when funct3 is 011, 110 or 111.
REQ-020 Writes SHALL occur at the rising edge when wr=1: funct3 000 (SB) writes wr_data[7:0] to the addressed lane, 001 (SH) writes wr_data[15:0] to the half lane, and 010 (SW) writes the full word.
REQ-021 A write SHALL leave all other lanes unchanged, and any other funct3 SHALL write nothing.
REQ-022 When wr and rd are both 1 in one cycle, rd_data SHALL show the pre-write contents; the new data SHALL be visible from the next cycle.
REQ-023 rd_cnt SHALL increment at each edge with rd=1, and wr_cnt SHALL increment at each edge where a write is performed.
REQ-024 Both counters SHALL saturate at 0xFFFF, never wrapping.
REQ-025 Access to the top word SHALL be addressed like any other word; no address wrap or aliasing beyond the ADDR_W bits is required.

Reset
REQ-026 While reset=1, regardless of clk, all storage words, rd_cnt, wr_cnt and misalign SHALL be 0.
REQ-027 A wr asserted in a cycle where reset is high SHALL be discarded.
REQ-028 Reset asserted between a write and a subsequent read SHALL cause that read to return 0.

Configuration
REQ-029 The feature SHALL be controlled by macro DMEM_ALIGN_CHECK_EN.
REQ-030 With DMEM_ALIGN_CHECK_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL be suppressed: no write, rd_data=0, and neither counter increments.
REQ-031 With DMEM_ALIGN_CHECK_EN defined, misalign SHALL be set at the edge of a suppressed access and held until reset.
REQ-032 Without DMEM_ALIGN_CHECK_EN, offending low address bits SHALL be ignored: a half access uses addr[1] only and a word access ignores addr[1:0].
REQ-033 Without DMEM_ALIGN_CHECK_EN, misalign SHALL be tied to 0 and counters SHALL count every access.

Verification
REQ-034 SW addr=0x010 data=0xDEADBEEF, then LW addr=0x010 -> rd_data=0xDEADBEEF; LB 0x013 -> 0xFFFFFFDE; LBU 0x013 -> 0x000000DE; LH 0x010 -> 0xFFFFBEEF.
REQ-035 SW 0x020=0x11223344, then SB 0x021 data=0xAA -> LW 0x020 returns 0x1122AA44; SH 0x022 data=0x5566 -> LW returns 0x5566AA44.
REQ-036 SW 0x030=0x1 then same-cycle wr+rd at 0x030 with data 0x2 -> rd_data=0x1 that cycle, 0x2 next cycle.
REQ-037 LW at 0x005 -> with macro: rd_data=0, misalign=1 after edge, rd_cnt unchanged; without macro: returns the word at 0x004, misalign=0, rd_cnt+1.
REQ-038 70000 consecutive rd cycles -> rd_cnt=0xFFFF; asserting reset mid-run -> rd_cnt, wr_cnt, misalign and storage read back 0 immediately.
